mac_result_drain: RTL
=====================

# mac_result_drain

Downstream stage of the 12x12 multiply-accumulate unit. It samples the 25-bit unsigned accumulator output once per programmable accumulation window, then rounds and saturates each sample to a narrower word. Results are held in a small FIFO and presented on a valid/ready output port for the next consumer (bus interface or output register bank).

## Interface
Parameters:
- IN_W, 25, width of mac_in; matches the MAC accumulator output
- OUT_W, 16, width of out_data
- SHIFT, 8, right-shift applied with round-half-up before saturation
- DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  in  1  rising-edge clock, shared with the MAC
- reset  in  1  asynchronous, active-low; clears all state immediately
- mac_in  in  IN_W  accumulator value from the MAC, treated as unsigned
- acc_len  in  8  window length in cycles, sampled at start; 0 means no captures
- start  in  1  single-cycle pulse; enters or restarts RUN
- stop  in  1  single-cycle pulse; returns to IDLE
- out_data  out  OUT_W  FIFO head
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  high in RUN
- sat_flag  out  1  sticky; set when any captured sample saturated
- overflow  out  1  sticky; set when a capture was dropped because the FIFO was full

## Operation
- Reset values: out_data=0, out_valid=0, level=0, busy=0, sat_flag=0, overflow=0. State is IDLE and the window counter is 0.
- States:
  - IDLE: no captures.
  - RUN: the window counter is active.
- IDLE→RUN on start. This latches acc_len into len_q and loads the counter with len_q-1.
- In RUN, the counter decrements each cycle. In the cycle it equals 0, a capture occurs and the counter reloads len_q-1. With len_q=1, every cycle is a capture.
- len_q=0: stay in RUN (busy=1), never capture.
- start while in RUN: relatch acc_len and reload the counter. No capture occurs in that cycle.
- stop: go to IDLE next edge. A capture scheduled in the same cycle still occurs. If start and stop are both asserted, stop wins.
- Capture arithmetic:
  - r = (mac_in + 2^(SHIFT-1)) >> SHIFT, computed in IN_W+1 bits.
  - If r > 2^OUT_W-1, the pushed value is 2^OUT_W-1 and sat_flag is set. Otherwise r is pushed.
- FIFO: circular, DEPTH entries; push on capture, pop on out_valid && out_ready.
  - Full and push without pop: sample dropped, overflow set, contents unchanged.
  - Full and push with pop in the same cycle: both occur, level stays DEPTH, no overflow.
  - Empty and push: the value appears on out_data next cycle. There is no same-cycle bypass.
- sat_flag and overflow clear only on reset. The FIFO is not flushed on stop or start.
- Reset asserted mid-operation: all outputs go to reset values asynchronously and FIFO contents are discarded.

## Timing
- A capture in cycle N (counter=0 at edge N) makes the result visible on out_data/out_valid after edge N, i.e. 1-cycle latency.
- The first capture after start comes len_q cycles after the start edge.
- level updates on the same edge as push/pop. out_data always shows the head entry and changes only on a pop or on a push into an empty FIFO.
- out_valid never depends combinationally on out_ready.
- Throughput: one result per cycle when len_q=1 and out_ready=1.

## Test plan
- Reset values and basic capture:
  - Stimulus: reset low, then release; acc_len=4, start, mac_in held at 384, out_ready=1.
  - Required: out_data=2 and out_valid=1 for one cycle every 4 cycles, the first 5 edges after start. sat_flag=0.
- Rounding and saturation:
  - mac_in=127 → 0. mac_in=128 → 1. mac_in=0x1FFFFFF → 0xFFFF with sat_flag=1.
  - mac_in=0xFFFF7F → 0xFFFF, with sat_flag still unset if no earlier saturation.
- Backpressure and overflow:
  - Stimulus: out_ready=0, acc_len=1, 5 captures.
  - Required: level=4, overflow=1, out_data = first sample.
  - Then out_ready=1 drains exactly 4 entries in order.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, acc_len=1, out_ready=1.
  - Required: level stays 4 and overflow stays 0 for 10 cycles, with sequential values streaming out.
- Control corners:
  - acc_len=0 with start: busy=1, no captures for 600 cycles.
  - Same-cycle start+stop: ends in IDLE.
  - start mid-window: the next capture comes acc_len cycles later.
- Async reset mid-run:
  - Stimulus: assert reset between clock edges with level=3.
  - Required: out_valid=0, level=0, busy=0 immediately. After release, no captures occur until start.

Source files
------------

// File: rtl/mac_result_drain.sv
// Samples the MAC accumulator once per programmable window, rounds/saturates
// each sample to OUT_W bits and queues it in a small FIFO with a valid/ready port.
module mac_result_drain #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          mac_in,
    input  logic [7:0]               acc_len,
    input  logic                     start,
    input  logic                     stop,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     sat_flag,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: a word transfers on any rising edge where out_valid && out_ready;
    // out_valid is purely registered FIFO state and never looks at out_ready.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic       capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // stop overrides start; a capture due in the stop cycle still happens.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    len_d   = acc_len;
                    cnt_d   = acc_len - 8'd1;
                end
            end
            RUN: begin
                if (start && !stop) begin
                    len_d = acc_len;
                    cnt_d = acc_len - 8'd1;
                end else if (len_q != 8'd0 && cnt_q == 8'd0) begin
                    capture = 1'b1;
                    cnt_d   = len_q - 8'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
                if (stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);

    // Round half up in IN_W+1 bits so the carry out of the add is kept.
    localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [IN_W:0] MAXV = {{(IN_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic [IN_W:0]      rounded;
    logic               sat;
    logic [OUT_W-1:0]   push_val;

    assign rounded  = ({1'b0, mac_in} + HALF) >> SHIFT;
    assign sat      = (rounded > MAXV);
    assign push_val = sat ? {OUT_W{1'b1}} : rounded[OUT_W-1:0];

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;
    logic             full, pop, push;

    assign out_valid = (level_q != '0);
    assign full      = (level_q == (AW + 1)'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = capture && (!full || pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        sat_d   = sat_q;
        ovf_d   = ovf_q;
        if (push) begin
            wr_d = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW + 1)'(1);
        end
        if (capture && sat) begin
            sat_d = 1'b1;
        end
        if (capture && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_val;
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data = mem_q[rd_q];
    assign level    = level_q;
    assign sat_flag = sat_q;
    assign overflow = ovf_q;

endmodule
